ir_scan_seq: RTL and testbench
==============================

# ir_scan_seq

Round-robin sequencer that sits directly upstream of the A2D SPI interface. On a programmable period it walks channels 0..NUM_CH-1 and for each channel pulses a conversion request, waits for completion and captures the 12-bit result. It presents a raw and an IIR-filtered reading per channel to the line-sensing logic. It owns all scan timing so downstream consumers only watch `scan_done` and the per-channel registers.

## Interface
Parameters:
- `NUM_CH`, 4: channels scanned per round, 1..8; channel index = A2D channel number.
- `SCAN_PERIOD`, 50000: clocks between round starts (1 kHz at 50 MHz); ≥ 2.
- `ALPHA_SHIFT`, 2: IIR shift, 0..4; 0 makes filtered equal to raw.
- `TIMEOUT`, 4096: clocks allowed from `strt_cnv` to `cnv_cmplt` before `tmo_err` sets.

Ports:
- `clk` in 1: system clock (50 MHz).
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: scanning enable; low holds the period timer cleared.
- `cnv_cmplt` in 1: one-cycle pulse from the A2D interface, conversion done.
- `res` in 12: A2D result, valid in the `cnv_cmplt` cycle.
- `strt_cnv` out 1: one-cycle conversion request to the A2D interface.
- `chnnl` out 3: channel for the current conversion.
- `ir_raw` out NUM_CH×12: last raw result per channel.
- `ir_filt` out NUM_CH×12: filtered result per channel.
- `ir_vld` out NUM_CH: channel has at least one sample since reset.
- `scan_done` out 1: one-cycle pulse, round complete, all outputs updated.
- `ovr` out 1: sticky, a period tick arrived while a round was in progress.
- `tmo_err` out 1: sticky, a conversion exceeded TIMEOUT.

## Operation
- Reset values: state IDLE, `strt_cnv`/`scan_done` 0, `chnnl` 0, all `ir_raw`/`ir_filt` 0, `ir_vld` 0, `ovr`/`tmo_err` 0, timers 0.
- Period timer counts 0..SCAN_PERIOD-1 while `en`. `tick` fires at SCAN_PERIOD-1, then the timer wraps to 0. `en` low clears the timer and suppresses `tick`.
- FSM states:
  - IDLE: on `tick`, set idx←0 and go to START.
  - START: drive `strt_cnv`=1 and clear the timeout counter. Go to WAIT.
  - WAIT: on `cnv_cmplt`, set `ir_raw[idx]`←`res` and go to UPDATE. Otherwise increment the timeout counter. On reaching TIMEOUT, set `tmo_err` and keep waiting; the round is never aborted, because the A2D cannot be cancelled.
  - UPDATE: update the filter for idx and set `ir_vld[idx]`. If idx==NUM_CH-1 go to DONE; else idx++ and go to START.
  - DONE: `scan_done`=1, go to IDLE.
- `chnnl` = idx, held stable from START through the `cnv_cmplt` cycle.
- Filter:
  - If `ir_vld[idx]`==0, load `ir_filt` directly from raw.
  - Otherwise d = {1'b0,raw} − {1'b0,filt} as 13-bit signed. filt ← filt + (d >>> ALPHA_SHIFT), using an arithmetic shift with 13-bit sum truncated to 12.
  - The result always stays within 0..4095; no saturation logic is needed.
- A `tick` outside IDLE sets `ovr` and is dropped; it is not queued.
- `en` falling mid-round: the round completes normally, and no new round starts.
- `ovr` and `tmo_err` clear only on `rst`.
- Reset mid-round: immediate return to IDLE with every output at its reset value. The top level derives the A2D interface's reset from the same source, so both blocks restart together.

## Timing
- `strt_cnv` is a Moore output of START: exactly one cycle per channel, 1 cycle after `tick` (channel 0) or after UPDATE.
- `ir_raw[idx]` is visible the cycle after `cnv_cmplt`. `ir_filt[idx]` is visible the cycle after UPDATE.
- Per-channel overhead is 3 clocks (START, UPDATE, and the `cnv_cmplt` cycle) plus the A2D latency. Round overhead adds 1 clock for DONE.
- `scan_done` is asserted in the cycle after the last UPDATE, and all NUM_CH values are already stable.
- Outputs are registered or decoded from registered state only; no combinational path runs from `res`/`cnv_cmplt` to any output.

## Structure
- Package `ir_scan_pkg` holds the `state_t` enum {IDLE,START,WAIT,UPDATE,DONE}, `RES_W`=12 and `CH_W`=3.
- Sub-module `ir_iir_filt` is a single shared instance, purely combinational. Inputs: `raw`, `filt`, `first`. Output: next `filt`. Parameterised by ALPHA_SHIFT and muxed by idx.

## Test plan
Common setup: NUM_CH=4, SCAN_PERIOD=100, ALPHA_SHIFT=2. The A2D model answers `res`=0x100·(ch+1) 40 clocks after `strt_cnv`.
- First round after `en`: expect `strt_cnv` pulses with `chnnl` 0,1,2,3 in order, `ir_raw`=`ir_filt`={0x100,0x200,0x300,0x400}, `ir_vld`=4'hF, and one `scan_done`.
- Filter steps on ch0 from filt 0x100:
  - `res` 0x500 → `ir_filt[0]`=0x200.
  - Then `res` 0x000 → 0x180.
  - Then `res` 0xFFF: d=+0xE7F, d>>>2=+0x39F, filt=0x180+0x39F=0x51F. Per the filter rule the filt value never leaves 0..4095.
- Filter extremes: filt 0x001 with `res` 0 → 0x000, not 0xFFF. filt 0x000 with `res` 0xFFF → 0x3FF.
- A2D latency set to 200 clocks: expect `ovr`=1 and exactly one round per completed scan, with no back-to-back double round.
- Model never returns `cnv_cmplt`: `tmo_err` rises exactly TIMEOUT clocks after `strt_cnv`, and the FSM stays in WAIT.
- Assert `rst` during WAIT of ch2: all outputs return to reset values asynchronously. After release with `en`, the next round starts at ch0.

Source files
------------

// File: rtl/ir_scan_pkg.sv
// Shared types and widths for the IR scan sequencer.
package ir_scan_pkg;

   localparam int RES_W = 12;   // A2D result width
   localparam int CH_W  = 3;    // A2D channel select width

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT,
      UPDATE,
      DONE
   } state_t;

endpackage

// File: rtl/ir_iir_filt.sv
// First-order IIR step: filt + (raw - filt) >>> ALPHA_SHIFT, or raw on the
// first sample of a channel. Purely combinational; one instance is shared by
// all channels.
module ir_iir_filt
   import ir_scan_pkg::*;
#(
   parameter int ALPHA_SHIFT = 2
) (
   input  logic [RES_W-1:0] raw,
   input  logic [RES_W-1:0] filt,
   input  logic             first,
   output logic [RES_W-1:0] filt_next
);

   logic signed [RES_W:0] diff;
   logic [RES_W-1:0]      step;

   // Signed difference, arithmetic shift, then a 12-bit wrap-around add.
   // The shifted step never exceeds the distance to raw, so the sum cannot
   // actually leave 0..4095 and the truncation never loses information.
   always_comb begin
      diff      = $signed({1'b0, raw}) - $signed({1'b0, filt});
      step      = RES_W'(diff >>> ALPHA_SHIFT);
      filt_next = first ? raw : (filt + step);
   end

endmodule

// File: rtl/ir_scan_seq.sv
// Round-robin A2D scan sequencer: on each period tick it converts channels
// 0..NUM_CH-1, stores raw and IIR-filtered results per channel and pulses
// scan_done when the whole round is stable.
module ir_scan_seq
   import ir_scan_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int SCAN_PERIOD = 50000,
   parameter int ALPHA_SHIFT = 2,
   parameter int TIMEOUT     = 4096
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    cnv_cmplt,
   input  logic [RES_W-1:0]        res,
   output logic                    strt_cnv,
   output logic [CH_W-1:0]         chnnl,
   output logic [NUM_CH*RES_W-1:0] ir_raw,
   output logic [NUM_CH*RES_W-1:0] ir_filt,
   output logic [NUM_CH-1:0]       ir_vld,
   output logic                    scan_done,
   output logic                    ovr,
   output logic                    tmo_err
);

   localparam int PER_W = (SCAN_PERIOD > 2) ? $clog2(SCAN_PERIOD) : 1;
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   logic [PER_W-1:0] timer_reg;
   logic             tick;

   state_t           state_reg, state_next;
   logic [CH_W-1:0]  idx_reg, idx_next;
   logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
   logic             tmo_err_reg, tmo_err_next;
   logic             ovr_reg, ovr_next;
   logic             cap_raw;
   logic             upd;

   logic [RES_W-1:0] raw_reg  [NUM_CH];
   logic [RES_W-1:0] filt_reg [NUM_CH];
   logic             vld_reg  [NUM_CH];

   logic [RES_W-1:0] raw_sel;
   logic [RES_W-1:0] filt_sel;
   logic             first_sel;
   logic [RES_W-1:0] filt_new;

   assign tick = en && (timer_reg == PER_W'(SCAN_PERIOD - 1));

   // Free-running period timer; held at zero while scanning is disabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         timer_reg <= '0;
      else if (!en || tick)
         timer_reg <= '0;
      else
         timer_reg <= timer_reg + 1'b1;
   end

   // FSM and control state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         idx_reg     <= '0;
         tmo_cnt_reg <= '0;
         tmo_err_reg <= 1'b0;
         ovr_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         idx_reg     <= idx_next;
         tmo_cnt_reg <= tmo_cnt_next;
         tmo_err_reg <= tmo_err_next;
         ovr_reg     <= ovr_next;
      end
   end

   // Next-state logic, channel stepping, timeout watch and overrun detect.
   always_comb begin
      state_next   = state_reg;
      idx_next     = idx_reg;
      tmo_cnt_next = tmo_cnt_reg;
      tmo_err_next = tmo_err_reg;
      ovr_next     = ovr_reg;
      cap_raw      = 1'b0;
      upd          = 1'b0;

      // A tick during a round is dropped, not queued.
      if (tick && (state_reg != IDLE))
         ovr_next = 1'b1;

      case (state_reg)
         IDLE: begin
            if (tick) begin
               idx_next   = '0;
               state_next = START;
            end
         end
         START: begin
            tmo_cnt_next = '0;
            state_next   = WAIT;
         end
         WAIT: begin
            if (cnv_cmplt) begin
               cap_raw    = 1'b1;
               state_next = UPDATE;
            end else begin
               if (tmo_cnt_reg != TMO_W'(TIMEOUT))
                  tmo_cnt_next = tmo_cnt_reg + 1'b1;
               // In WAIT, tmo_cnt_reg trails the clocks since strt_cnv by
               // one; setting here makes the flag appear exactly TIMEOUT
               // clocks after strt_cnv. The conversion is never abandoned.
               if (tmo_cnt_reg == TMO_W'(TIMEOUT - 2))
                  tmo_err_next = 1'b1;
            end
         end
         UPDATE: begin
            upd = 1'b1;
            if (idx_reg == CH_W'(NUM_CH - 1)) begin
               state_next = DONE;
            end else begin
               idx_next   = idx_reg + 1'b1;
               state_next = START;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Select the current channel's registers for the shared filter.
   always_comb begin
      raw_sel   = '0;
      filt_sel  = '0;
      first_sel = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
         if (idx_reg == CH_W'(i)) begin
            raw_sel   = raw_reg[i];
            filt_sel  = filt_reg[i];
            first_sel = !vld_reg[i];
         end
      end
   end

   ir_iir_filt #(
      .ALPHA_SHIFT (ALPHA_SHIFT)
   ) u_filt (
      .raw       (raw_sel),
      .filt      (filt_sel),
      .first     (first_sel),
      .filt_next (filt_new)
   );

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         // Per-channel result storage: raw on completion, filter on UPDATE.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               raw_reg[gi]  <= '0;
               filt_reg[gi] <= '0;
               vld_reg[gi]  <= 1'b0;
            end else begin
               if (cap_raw && (idx_reg == CH_W'(gi)))
                  raw_reg[gi] <= res;
               if (upd && (idx_reg == CH_W'(gi))) begin
                  filt_reg[gi] <= filt_new;
                  vld_reg[gi]  <= 1'b1;
               end
            end
         end

         assign ir_raw[gi*RES_W +: RES_W]  = raw_reg[gi];
         assign ir_filt[gi*RES_W +: RES_W] = filt_reg[gi];
         assign ir_vld[gi]                 = vld_reg[gi];
      end
   endgenerate

   assign strt_cnv  = (state_reg == START);
   assign scan_done = (state_reg == DONE);
   assign chnnl     = idx_reg;
   assign ovr       = ovr_reg;
   assign tmo_err   = tmo_err_reg;

endmodule

// File: tb/tb_ir_scan_seq.sv
// Self-checking bench for ir_scan_seq with a behavioural A2D model and a
// per-conversion scoreboard.
module tb_ir_scan_seq;

   localparam int NUM_CH      = 4;
   localparam int SCAN_PERIOD = 100;
   localparam int ALPHA_SHIFT = 2;
   localparam int TIMEOUT     = 300;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    en;
   logic                    cnv_cmplt;
   logic [11:0]             res;
   logic                    strt_cnv;
   logic [2:0]              chnnl;
   logic [NUM_CH*12-1:0]    ir_raw;
   logic [NUM_CH*12-1:0]    ir_filt;
   logic [NUM_CH-1:0]       ir_vld;
   logic                    scan_done;
   logic                    ovr;
   logic                    tmo_err;

   int errors = 0;
   int checks = 0;

   // A2D model controls
   int          lat     = 40;
   bit          no_resp = 1'b0;
   logic [11:0] res_tab [8];

   typedef struct {
      int          ch;
      logic [11:0] raw;
      logic [11:0] filt;
   } exp_t;
   exp_t sb[$];

   logic [11:0] m_filt [8];
   bit          m_vld  [8];

   int strt_count = 0;
   int done_count = 0;
   int strt_ch[$];

   ir_scan_seq #(
      .NUM_CH      (NUM_CH),
      .SCAN_PERIOD (SCAN_PERIOD),
      .ALPHA_SHIFT (ALPHA_SHIFT),
      .TIMEOUT     (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .cnv_cmplt (cnv_cmplt),
      .res       (res),
      .strt_cnv  (strt_cnv),
      .chnnl     (chnnl),
      .ir_raw    (ir_raw),
      .ir_filt   (ir_filt),
      .ir_vld    (ir_vld),
      .scan_done (scan_done),
      .ovr       (ovr),
      .tmo_err   (tmo_err)
   );

   always #5 clk = ~clk;

   // Reference filter written from the arithmetic definition.
   function automatic logic [11:0] model_filt(input logic [11:0] raw,
                                              input logic [11:0] filt,
                                              input bit first);
      int d;
      if (first) return raw;
      d = int'(raw) - int'(filt);
      d = d >>> ALPHA_SHIFT;
      return 12'((int'(filt) + d) & 32'hFFF);
   endfunction

   // A2D model: answers lat clocks after strt_cnv; pushes expectations.
   initial begin : a2d_model
      int   remaining;
      int   cur_ch;
      bit   busy;
      exp_t e;
      cnv_cmplt = 1'b0;
      res       = '0;
      remaining = 0;
      cur_ch    = 0;
      busy      = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         cnv_cmplt = 1'b0;
         if (rst) begin
            busy = 1'b0;
         end else begin
            if (busy) begin
               remaining--;
               if (remaining <= 0) begin
                  busy = 1'b0;
                  if (!no_resp) begin
                     res       = res_tab[cur_ch];
                     cnv_cmplt = 1'b1;
                     e.ch      = cur_ch;
                     e.raw     = res_tab[cur_ch];
                     e.filt    = model_filt(e.raw, m_filt[cur_ch], !m_vld[cur_ch]);
                     m_filt[cur_ch] = e.filt;
                     m_vld[cur_ch]  = 1'b1;
                     sb.push_back(e);
                  end
               end
            end
            if (strt_cnv) begin
               busy      = 1'b1;
               remaining = lat;
               cur_ch    = int'(chnnl);
            end
         end
      end
   end

   // Event monitor: counts request/done pulses and records channel order.
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (strt_cnv) begin
               strt_count++;
               strt_ch.push_back(int'(chnnl));
            end
            if (scan_done) done_count++;
         end
      end
   end

   // Scoreboard: raw the cycle after cnv_cmplt, filt/vld one cycle later.
   initial begin : scoreboard
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && cnv_cmplt) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL sb_empty: completion with no expectation queued");
            end else begin
               e = sb.pop_front();
               @(negedge clk);
               if (!rst) begin
                  checks++;
                  if (ir_raw[e.ch*12 +: 12] !== e.raw) begin
                     errors++;
                     $display("FAIL sb_raw ch%0d: got %h expected %h", e.ch, ir_raw[e.ch*12 +: 12], e.raw);
                  end
               end
               @(negedge clk);
               if (!rst) begin
                  checks++;
                  if (ir_filt[e.ch*12 +: 12] !== e.filt || ir_vld[e.ch] !== 1'b1) begin
                     errors++;
                     $display("FAIL sb_filt ch%0d: got %h vld %b expected %h vld 1", e.ch, ir_filt[e.ch*12 +: 12], ir_vld[e.ch], e.filt);
                  end
               end
               $display("xfer ch%0d raw=%h filt=%h", e.ch, e.raw, e.filt);
            end
         end
      end
   end

   task automatic set_default_tab();
      for (int i = 0; i < 8; i++) res_tab[i] = 12'(12'h100 * (i + 1));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      en  = 1'b0;
      repeat (3) @(negedge clk);
      sb.delete();
      for (int i = 0; i < 8; i++) begin
         m_filt[i] = '0;
         m_vld[i]  = 1'b0;
      end
      strt_count = 0;
      done_count = 0;
      strt_ch.delete();
      rst = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while (!scan_done && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!scan_done) begin
         checks++;
         errors++;
         $display("FAIL %s_done_timeout: no scan_done within %0d cycles", tag, budget);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      en  = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (strt_cnv !== 1'b0)  begin errors++; $display("FAIL rst_strt: got %b expected 0", strt_cnv); end
      checks++; if (scan_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", scan_done); end
      checks++; if (chnnl !== 3'd0)     begin errors++; $display("FAIL rst_chnnl: got %0d expected 0", chnnl); end
      checks++; if (ir_raw !== '0)      begin errors++; $display("FAIL rst_raw: got %h expected 0", ir_raw); end
      checks++; if (ir_filt !== '0)     begin errors++; $display("FAIL rst_filt: got %h expected 0", ir_filt); end
      checks++; if (ir_vld !== '0)      begin errors++; $display("FAIL rst_vld: got %b expected 0", ir_vld); end
      checks++; if (ovr !== 1'b0 || tmo_err !== 1'b0) begin errors++; $display("FAIL rst_flags: ovr %b tmo %b expected 0 0", ovr, tmo_err); end
      rst = 1'b0;
      repeat (SCAN_PERIOD + 50) @(negedge clk);
      checks++; if (strt_count != 0) begin errors++; $display("FAIL en_low_idle: got %0d starts expected 0", strt_count); end
      $display("reset: done");
   endtask

   task automatic test_first_round();
      int n;
      do_reset();
      lat = 40;
      set_default_tab();
      en = 1'b1;
      n = 0;
      while (!strt_cnv && n < 3 * SCAN_PERIOD) begin
         @(negedge clk);
         n++;
      end
      checks++; if (n != SCAN_PERIOD) begin errors++; $display("FAIL first_start_lat: got %0d expected %0d", n, SCAN_PERIOD); end
      wait_done(1000, "first");
      checks++;
      if (strt_ch.size() != 4 || strt_ch[0] != 0 || strt_ch[1] != 1 || strt_ch[2] != 2 || strt_ch[3] != 3) begin
         errors++;
         $display("FAIL chan_order: got %p expected '{0,1,2,3}", strt_ch);
      end
      checks++; if (ir_raw !== 48'h400_300_200_100)  begin errors++; $display("FAIL first_raw: got %h expected 400300200100", ir_raw); end
      checks++; if (ir_filt !== 48'h400_300_200_100) begin errors++; $display("FAIL first_filt: got %h expected 400300200100", ir_filt); end
      checks++; if (ir_vld !== 4'hF) begin errors++; $display("FAIL first_vld: got %b expected 1111", ir_vld); end
      checks++; if (done_count != 1) begin errors++; $display("FAIL first_done_cnt: got %0d expected 1", done_count); end
      @(negedge clk);
      checks++; if (scan_done !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b expected 0", scan_done); end
      $display("first_round: done");
   endtask

   task automatic test_filter_steps();
      logic [11:0] vals [3];
      logic [11:0] exps [3];
      vals = '{12'h500, 12'h000, 12'hFFF};
      exps = '{12'h200, 12'h180, 12'h51F};
      for (int i = 0; i < 3; i++) begin
         res_tab[0] = vals[i];
         wait_done(1000, "step");
         checks++;
         if (ir_filt[11:0] !== exps[i] || ir_raw[11:0] !== vals[i]) begin
            errors++;
            $display("FAIL filt_step%0d: got raw %h filt %h expected raw %h filt %h", i, ir_raw[11:0], ir_filt[11:0], vals[i], exps[i]);
         end
         $display("filter_step: res=%h filt=%h", vals[i], ir_filt[11:0]);
      end
      set_default_tab();
   endtask

   task automatic test_filter_extremes();
      do_reset();
      set_default_tab();
      res_tab[0] = 12'h001;
      res_tab[1] = 12'h000;
      en = 1'b1;
      wait_done(1000, "ext1");
      res_tab[0] = 12'h000;
      res_tab[1] = 12'hFFF;
      wait_done(1000, "ext2");
      checks++; if (ir_filt[11:0] !== 12'h000)  begin errors++; $display("FAIL filt_low: got %h expected 000", ir_filt[11:0]); end
      checks++; if (ir_filt[23:12] !== 12'h3FF) begin errors++; $display("FAIL filt_high: got %h expected 3ff", ir_filt[23:12]); end
      set_default_tab();
      $display("filter_extremes: done");
   endtask

   task automatic test_overrun();
      do_reset();
      checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", ovr); end
      lat = 200;
      en  = 1'b1;
      wait_done(2000, "ovr1");
      wait_done(2000, "ovr2");
      checks++; if (strt_count != 8) begin errors++; $display("FAIL ovr_starts: got %0d expected 8", strt_count); end
      checks++; if (done_count != 2) begin errors++; $display("FAIL ovr_dones: got %0d expected 2", done_count); end
      checks++; if (ovr !== 1'b1)    begin errors++; $display("FAIL ovr_flag: got %b expected 1", ovr); end
      lat = 40;
      $display("overrun: done");
   endtask

   task automatic test_timeout();
      int n;
      int starts;
      do_reset();
      no_resp = 1'b1;
      en      = 1'b1;
      n = 0;
      while (!strt_cnv && n < 3 * SCAN_PERIOD) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (!tmo_err && n < TIMEOUT + 50) begin
         @(negedge clk);
         n++;
      end
      checks++; if (n != TIMEOUT) begin errors++; $display("FAIL tmo_lat: got %0d expected %0d", n, TIMEOUT); end
      starts = strt_count;
      repeat (250) @(negedge clk);
      checks++; if (strt_count != starts || done_count != 0) begin errors++; $display("FAIL tmo_stall: got starts %0d->%0d dones %0d expected no change", starts, strt_count, done_count); end
      checks++; if (chnnl !== 3'd0 || tmo_err !== 1'b1) begin errors++; $display("FAIL tmo_hold: got chnnl %0d tmo %b expected 0 1", chnnl, tmo_err); end
      no_resp = 1'b0;
      $display("timeout: done");
   endtask

   task automatic test_reset_mid_round();
      int n;
      do_reset();
      lat = 40;
      en  = 1'b1;
      n = 0;
      while (!(strt_cnv && chnnl == 3'd2) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      repeat (5) @(negedge clk);
      checks++; if (ir_vld !== 4'b0011) begin errors++; $display("FAIL mid_vld: got %b expected 0011", ir_vld); end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (ir_raw !== '0 || ir_filt !== '0 || ir_vld !== '0 || chnnl !== 3'd0 || strt_cnv !== 1'b0 || ovr !== 1'b0) begin
         errors++;
         $display("FAIL async_rst: got raw %h filt %h vld %b ch %0d ovr %b expected all 0", ir_raw, ir_filt, ir_vld, chnnl, ovr);
      end
      @(negedge clk);
      @(negedge clk);
      sb.delete();
      for (int i = 0; i < 8; i++) begin
         m_filt[i] = '0;
         m_vld[i]  = 1'b0;
      end
      strt_ch.delete();
      rst = 1'b0;
      n = 0;
      while (!strt_cnv && n < 3 * SCAN_PERIOD) begin
         @(negedge clk);
         n++;
      end
      checks++; if (!strt_cnv || chnnl !== 3'd0) begin errors++; $display("FAIL restart_ch: got strt %b ch %0d expected 1 0", strt_cnv, chnnl); end
      $display("reset_mid_round: done");
   endtask

   initial begin
      rst = 1'b1;
      en  = 1'b0;
      set_default_tab();
      for (int i = 0; i < 8; i++) begin
         m_filt[i] = '0;
         m_vld[i]  = 1'b0;
      end
      test_reset();
      test_first_round();
      test_filter_steps();
      test_filter_extremes();
      test_overrun();
      test_timeout();
      test_reset_mid_round();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
